// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons, one neuron updated per clock.
// Optional adaptive thresholds are enabled by defining LIF_ADAPTIVE_TH_EN.
module lif_neuron_array #(
   parameter int N_NEURONS   = 4,
   parameter int W           = 8,
   parameter int BETA        = 112,
   parameter int TH_INIT     = 100,
   parameter int TH_MIN      = 8,
   parameter int TH_MAX      = 220,
   parameter int ADAPT_SHIFT = 3,
   parameter int REFRACTORY  = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         step_valid,
   output logic                         step_ready,
   input  logic [N_NEURONS*W-1:0]       current,
   input  logic                         learn_en,
   output logic [N_NEURONS-1:0]         spike,
   output logic                         spike_valid,
   input  logic [$clog2(N_NEURONS)-1:0] mem_sel,
   output logic [W-1:0]                 mem_out,
   output logic [W-1:0]                 th_out
);

   localparam int IW = $clog2(N_NEURONS);
   localparam int RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N_NEURONS - 1);
   localparam logic [IW:0]   N_L      = (IW + 1)'(N_NEURONS);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

   state_t                 state;
   logic [IW-1:0]          idx;
   logic [N_NEURONS*W-1:0] cur_q;
   logic [N_NEURONS-1:0]   collected;
   logic [W-1:0]           v    [N_NEURONS];
   logic [RW-1:0]          refr [N_NEURONS];

   logic [W-1:0]   v_cur, i_cur, th_cur, leak, v_int;
   logic [RW-1:0]  refr_cur;
   logic [W+6:0]   prod;
   logic [W:0]     sum;
   logic           fire, refr_busy, sel_in_range;

`ifdef LIF_ADAPTIVE_TH_EN
   logic [W-1:0] th [N_NEURONS];
   logic         learn_q;
   logic [W-1:0] th_step, th_up, th_dn, th_dn_diff;
   logic [W:0]   th_up_sum;

   assign th_cur     = th[idx];
   assign th_step    = th_cur >> ADAPT_SHIFT;
   assign th_up_sum  = {1'b0, th_cur} + {1'b0, th_step};
   assign th_up      = (th_up_sum > (W + 1)'(TH_MAX)) ? W'(TH_MAX) : th_up_sum[W-1:0];
   assign th_dn_diff = th_cur - th_step;
   assign th_dn      = (th_dn_diff < W'(TH_MIN)) ? W'(TH_MIN) : th_dn_diff;
`else
   logic unused_learn;

   assign unused_learn = learn_en;
   assign th_cur       = W'(TH_INIT);
`endif

   assign v_cur        = v[idx];
   assign refr_cur     = refr[idx];
   assign i_cur        = cur_q[idx*W +: W];
   assign prod         = {7'b0, v_cur} * (W + 7)'(BETA);
   assign leak         = W'(prod >> 7);
   assign sum          = {1'b0, i_cur} + {1'b0, leak};
   // Saturate instead of wrapping so a strong input never looks like a weak one.
   assign v_int        = sum[W] ? {W{1'b1}} : sum[W-1:0];
   assign refr_busy    = (refr_cur != '0);
   assign fire         = !refr_busy && (v_cur >= th_cur);
   assign sel_in_range = ({1'b0, mem_sel} < N_L);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= '0;
         cur_q       <= '0;
         collected   <= '0;
         step_ready  <= 1'b1;
         spike       <= '0;
         spike_valid <= 1'b0;
         mem_out     <= '0;
         th_out      <= W'(TH_INIT);
         // NOTE: the neuron state arrays are reset explicitly, so they map to flops, not RAM.
         for (int i = 0; i < N_NEURONS; i++) begin
            v[i]    <= '0;
            refr[i] <= '0;
`ifdef LIF_ADAPTIVE_TH_EN
            th[i]   <= W'(TH_INIT);
`endif
         end
`ifdef LIF_ADAPTIVE_TH_EN
         learn_q <= 1'b0;
`endif
      end else begin
         mem_out     <= sel_in_range ? v[mem_sel] : '0;
`ifdef LIF_ADAPTIVE_TH_EN
         th_out      <= sel_in_range ? th[mem_sel] : '0;
`else
         th_out      <= sel_in_range ? W'(TH_INIT) : '0;
`endif
         spike_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (step_valid) begin
                  cur_q      <= current;
`ifdef LIF_ADAPTIVE_TH_EN
                  learn_q    <= learn_en;
`endif
                  idx        <= '0;
                  collected  <= '0;
                  step_ready <= 1'b0;
                  state      <= S_UPDATE;
               end
            end

            S_UPDATE: begin
               collected[idx] <= fire;
               if (refr_busy) begin
                  v[idx]    <= '0;
                  refr[idx] <= refr_cur - RW'(1);
               end else if (fire) begin
                  v[idx]    <= '0;
                  refr[idx] <= RW'(REFRACTORY);
`ifdef LIF_ADAPTIVE_TH_EN
                  if (learn_q) th[idx] <= th_up;
`endif
               end else begin
                  v[idx]    <= v_int;
`ifdef LIF_ADAPTIVE_TH_EN
                  if (learn_q) th[idx] <= th_dn;
`endif
               end

               if (idx == IDX_LAST) state <= S_DONE;
               else                 idx   <= idx + IW'(1);
            end

            S_DONE: begin
               spike       <= collected;
               spike_valid <= 1'b1;
               step_ready  <= 1'b1;
               state       <= S_IDLE;
            end

            default: begin
               state      <= S_IDLE;
               step_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed testbench for lif_neuron_array with a behavioural neuron model and a spike scoreboard.
// Expected thresholds follow LIF_ADAPTIVE_TH_EN when it is defined.
module tb_lif_neuron_array;

`ifdef LIF_ADAPTIVE_TH_EN
   localparam bit ADAPT = 1'b1;
`else
   localparam bit ADAPT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        step_valid;
   logic        step_ready;
   logic [31:0] current;
   logic        learn_en;
   logic [3:0]  spike;
   logic        spike_valid;
   logic [1:0]  mem_sel;
   logic [7:0]  mem_out;
   logic [7:0]  th_out;

   int n_checks = 0;
   int n_pass   = 0;

   int m_v [4];
   int m_th [4];
   int m_refr [4];
   logic [3:0] exp_spk [$];

   always #5 clk = ~clk;

   lif_neuron_array dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_valid  (step_valid),
      .step_ready  (step_ready),
      .current     (current),
      .learn_en    (learn_en),
      .spike       (spike),
      .spike_valid (spike_valid),
      .mem_sel     (mem_sel),
      .mem_out     (mem_out),
      .th_out      (th_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_v[i]    = 0;
         m_th[i]   = 100;
         m_refr[i] = 0;
      end
      exp_spk.delete();
   endtask

   task automatic model_step(input logic [31:0] cur, input bit learn, output logic [3:0] spk);
      for (int i = 0; i < 4; i++) begin
         int s;
         spk[i] = 1'b0;
         if (m_refr[i] > 0) begin
            m_v[i] = 0;
            m_refr[i] = m_refr[i] - 1;
         end else if (m_v[i] >= m_th[i]) begin
            spk[i] = 1'b1;
            m_v[i] = 0;
            m_refr[i] = 2;
            if (ADAPT && learn) begin
               s = m_th[i] + m_th[i] / 8;
               m_th[i] = (s > 220) ? 220 : s;
            end
         end else begin
            s = int'(cur[i*8 +: 8]) + (m_v[i] * 112) / 128;
            m_v[i] = (s > 255) ? 255 : s;
            if (ADAPT && learn) begin
               s = m_th[i] - m_th[i] / 8;
               m_th[i] = (s < 8) ? 8 : s;
            end
         end
      end
   endtask

   task automatic hard_reset();
      step_valid = 1'b0;
      rst_n = 1'b0;
      #12;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one full timestep and compares latency, pulse width and the spike vector.
   task automatic do_step(input logic [31:0] cur, input bit learn, input string tag);
      logic [3:0] spk;
      int n;
      int waited = 0;
      @(negedge clk);
      while (!step_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_ready"}, step_ready, 1'b1);
      current    = cur;
      learn_en   = learn;
      step_valid = 1'b1;
      @(posedge clk);
      #1;
      step_valid = 1'b0;
      model_step(cur, learn, spk);
      exp_spk.push_back(spk);
      n = 0;
      while (n < 20) begin
         @(posedge clk);
         n++;
         #1;
         if (spike_valid) break;
      end
      check({tag, "_latency"}, n, 5);
      if (spike_valid) check({tag, "_spike"}, spike, exp_spk.pop_front());
      else if (exp_spk.size() > 0) void'(exp_spk.pop_front());
      @(posedge clk);
      #1;
      check({tag, "_pulse_width"}, spike_valid, 1'b0);
   endtask

   task automatic readback(input int i, input string tag);
      @(negedge clk);
      mem_sel = 2'(i);
      @(posedge clk);
      #1;
      check({tag, "_mem"}, mem_out, m_v[i]);
      check({tag, "_th"}, th_out, m_th[i]);
   endtask

   task automatic read_mem(input int i, output logic [7:0] mv, output logic [7:0] tv);
      @(negedge clk);
      mem_sel = 2'(i);
      @(posedge clk);
      #1;
      mv = mem_out;
      tv = th_out;
   endtask

   initial begin
      logic [7:0] mv, tv;
      int exp_v0 [6];
      int accepts, first_acc, gap, pulses;
      exp_v0 = '{60, 112, 0, 0, 0, 60};
      step_valid = 1'b0;
      current    = '0;
      learn_en   = 1'b0;
      mem_sel    = '0;

      // Reset state
      hard_reset();
      #1;
      check("rst_ready", step_ready, 1'b1);
      check("rst_spike", spike, 4'b0);
      check("rst_spike_valid", spike_valid, 1'b0);
      for (int i = 0; i < 4; i++) readback(i, $sformatf("rst_n%0d", i));

      // Leak and fire on neuron0, then refractory hold
      for (int s = 0; s < 6; s++) begin
         do_step({8'd0, 8'd0, 8'd0, 8'd60}, 1'b0, $sformatf("leak_s%0d", s + 1));
         read_mem(0, mv, tv);
         check($sformatf("leak_v0_s%0d", s + 1), mv, exp_v0[s]);
      end
      readback(1, "leak_n1");

      // Saturation: 255 + leak(50) must clamp to 255
      do_step({8'd0, 8'd0, 8'd50, 8'd0}, 1'b0, "sat_s1");
      do_step({8'd0, 8'd0, 8'd255, 8'd0}, 1'b0, "sat_s2");
      read_mem(1, mv, tv);
      check("sat_v1", mv, 8'd255);
      readback(0, "sat_n0");

      // Handshake with step_valid held high across sweeps
      accepts = 0; first_acc = 0; gap = 0; pulses = 0;
      @(negedge clk);
      current    = {8'd10, 8'd20, 8'd30, 8'd40};
      learn_en   = 1'b0;
      step_valid = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         logic [3:0] spk;
         if (k > 0) @(negedge clk);
         if (spike_valid) begin
            pulses++;
            if (exp_spk.size() > 0) check($sformatf("hs_spike_k%0d", k), spike, exp_spk.pop_front());
            else check("hs_spurious_pulse", spike_valid, 1'b0);
         end
         if (k == 12) step_valid = 1'b0;
         else if (step_ready) begin
            if (accepts == 0) first_acc = k;
            else if (accepts == 1) gap = k - first_acc;
            accepts++;
            model_step(current, 1'b0, spk);
            exp_spk.push_back(spk);
         end
      end
      check("hs_accepts", accepts, 2);
      check("hs_accept_gap", gap, 6);
      check("hs_pulses", pulses, 2);
      check("hs_queue_empty", exp_spk.size(), 0);
      for (int i = 0; i < 4; i++) readback(i, $sformatf("hs_n%0d", i));

      // Threshold adaptation on neuron0
      hard_reset();
      do_step({8'd0, 8'd0, 8'd0, 8'd60}, 1'b0, "adp_s1");
      do_step({8'd0, 8'd0, 8'd0, 8'd60}, 1'b0, "adp_s2");
      do_step({8'd0, 8'd0, 8'd0, 8'd60}, 1'b1, "adp_s3");
      read_mem(0, mv, tv);
      check("adp_th_fire", tv, ADAPT ? 8'd112 : 8'd100);
      do_step({8'd0, 8'd0, 8'd0, 8'd60}, 1'b1, "adp_s4");
      do_step({8'd0, 8'd0, 8'd0, 8'd60}, 1'b1, "adp_s5");
      read_mem(0, mv, tv);
      check("adp_th_refr", tv, ADAPT ? 8'd112 : 8'd100);
      do_step({8'd0, 8'd0, 8'd0, 8'd60}, 1'b1, "adp_s6");
      read_mem(0, mv, tv);
      check("adp_th_nospike", tv, ADAPT ? 8'd98 : 8'd100);
      for (int i = 1; i < 4; i++) readback(i, $sformatf("adp_n%0d", i));

      // Independence of neurons with distinct currents
      hard_reset();
      do_step({8'd200, 8'd60, 8'd30, 8'd0}, 1'b0, "ind_s1");
      do_step({8'd200, 8'd60, 8'd30, 8'd0}, 1'b0, "ind_s2");
      check("ind_only_n3", spike, 4'b1000);
      read_mem(1, mv, tv);
      check("ind_v1", mv, 8'd56);
      read_mem(2, mv, tv);
      check("ind_v2", mv, 8'd112);
      for (int i = 0; i < 4; i++) readback(i, $sformatf("ind_n%0d", i));

      // Reset in the middle of a sweep
      @(negedge clk);
      current    = {8'd200, 8'd200, 8'd200, 8'd200};
      step_valid = 1'b1;
      @(posedge clk);
      #1;
      step_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_ready", step_ready, 1'b1);
      check("midrst_spike", spike, 4'b0);
      check("midrst_spike_valid", spike_valid, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) readback(i, $sformatf("midrst_n%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
